// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: request side (a, b, c_in, sub) and result side (s, c_out, ovf).
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; the source holds its payload stable while valid=1 and ready=0, and ready never waits on valid.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract: CHUNK bits per clock, carry rippled through a register.
// A new operation is accepted in IDLE, takes WIDTH/CHUNK RUN cycles, then waits in DONE for the consumer.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus,
  output logic [1:0]     state_dbg
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

  if (CHUNK < 1 || WIDTH < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("serial_adder: CHUNK must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] s_r;
  logic             carry;
  logic [CW-1:0]    k;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             c_out_r;
  logic             ovf_r;

  logic [31:0]      sh;
  logic [CHUNK-1:0] a_ck;
  logic [CHUNK-1:0] b_ck;
  logic [CHUNK:0]   sum;
  logic             c_msb;
  logic [WIDTH-1:0] s_new;
  logic             last;

  // b_r already holds ~b for subtraction, so the chunk step is always a plain add.
  always_comb begin
    sh    = 32'(k) * 32'(CHUNK);
    a_ck  = CHUNK'(a_r >> sh);
    b_ck  = CHUNK'(b_r >> sh);
    sum   = {1'b0, a_ck} + {1'b0, b_ck} + {{CHUNK{1'b0}}, carry};
    c_msb = a_ck[CHUNK-1] ^ b_ck[CHUNK-1] ^ sum[CHUNK-1];
    s_new = (s_r & ~(CMASK << sh)) | (WIDTH'(sum[CHUNK-1:0]) << sh);
    last  = (k == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      s_r         <= '0;
      c_out_r     <= 1'b0;
      ovf_r       <= 1'b0;
      k           <= '0;
      a_r         <= '0;
      b_r         <= '0;
      carry       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= bus.sub ? ~bus.b : bus.b;
            carry      <= bus.sub | bus.c_in;
            k          <= '0;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          s_r   <= s_new;
          carry <= sum[CHUNK];
          k     <= k + CW'(1);
          if (last) begin
            c_out_r     <= sum[CHUNK];
            ovf_r       <= c_msb ^ sum[CHUNK];
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.s         = s_r;
  assign bus.c_out     = c_out_r;
  assign bus.ovf       = ovf_r;
  assign state_dbg     = state;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (8/1, 4/2, 8/8) share one stimulus driver selected by sel.
// Expected {ovf, c_out, s} values come from an arithmetic model and go through a scoreboard queue.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst;
  int         sel;
  logic       drv_valid;
  logic [7:0] drv_a;
  logic [7:0] drv_b;
  logic       drv_c;
  logic       drv_sub;
  logic       drv_out_ready;
  logic [1:0] dbg_c1;
  logic [1:0] dbg_c2;
  logic [1:0] dbg_c8;

  logic       obs_in_ready;
  logic       obs_out_valid;
  logic [9:0] obs_res;
  logic [1:0] obs_dbg;

  logic [9:0] exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if_c1 ();
  serial_adder_if #(.WIDTH(4)) if_c2 ();
  serial_adder_if #(.WIDTH(8)) if_c8 ();

  serial_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (.clk(clk), .rst(rst), .bus(if_c1), .state_dbg(dbg_c1));
  serial_adder #(.WIDTH(4), .CHUNK(2)) u_c2 (.clk(clk), .rst(rst), .bus(if_c2), .state_dbg(dbg_c2));
  serial_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (.clk(clk), .rst(rst), .bus(if_c8), .state_dbg(dbg_c8));

  assign if_c1.in_valid  = drv_valid && (sel == 0);
  assign if_c1.a         = drv_a;
  assign if_c1.b         = drv_b;
  assign if_c1.c_in      = drv_c;
  assign if_c1.sub       = drv_sub;
  assign if_c1.out_ready = drv_out_ready;
  assign if_c2.in_valid  = drv_valid && (sel == 1);
  assign if_c2.a         = drv_a[3:0];
  assign if_c2.b         = drv_b[3:0];
  assign if_c2.c_in      = drv_c;
  assign if_c2.sub       = drv_sub;
  assign if_c2.out_ready = drv_out_ready;
  assign if_c8.in_valid  = drv_valid && (sel == 2);
  assign if_c8.a         = drv_a;
  assign if_c8.b         = drv_b;
  assign if_c8.c_in      = drv_c;
  assign if_c8.sub       = drv_sub;
  assign if_c8.out_ready = drv_out_ready;

  always_comb begin
    obs_in_ready  = if_c1.in_ready;
    obs_out_valid = if_c1.out_valid;
    obs_res       = {if_c1.ovf, if_c1.c_out, if_c1.s};
    obs_dbg       = dbg_c1;
    case (sel)
      1: begin
        obs_in_ready  = if_c2.in_ready;
        obs_out_valid = if_c2.out_valid;
        obs_res       = {if_c2.ovf, if_c2.c_out, 4'b0, if_c2.s};
        obs_dbg       = dbg_c2;
      end
      2: begin
        obs_in_ready  = if_c8.in_ready;
        obs_out_valid = if_c8.out_valid;
        obs_res       = {if_c8.ovf, if_c8.c_out, if_c8.s};
        obs_dbg       = dbg_c8;
      end
      default: ;
    endcase
  end

  function automatic int width_of(int s_i);
    return (s_i == 1) ? 4 : 8;
  endfunction

  function automatic int steps_of(int s_i);
    return (s_i == 0) ? 8 : ((s_i == 1) ? 2 : 1);
  endfunction

  // Reference: integer add of a + b' + cin, signed overflow from operand/result sign bits.
  function automatic logic [9:0] model(int w, logic [7:0] a, logic [7:0] b, logic c, logic sb);
    int mask, aa, bb, cc, full, ss, sa, sbb, sr;
    logic [9:0] r;
    mask = (1 << w) - 1;
    aa   = int'(a) & mask;
    bb   = sb ? (~int'(b)) & mask : int'(b) & mask;
    cc   = sb ? 1 : int'(c);
    full = aa + bb + cc;
    ss   = full & mask;
    sa   = (aa >> (w - 1)) & 1;
    sbb  = (bb >> (w - 1)) & 1;
    sr   = (ss >> (w - 1)) & 1;
    r[7:0] = 8'(ss);
    r[8]   = ((full >> w) & 1) != 0;
    r[9]   = (sa == sbb) && (sr != sa);
    return r;
  endfunction

  task automatic do_op(input int s_i, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic sb, input int hold, input string name);
    int t;
    int lat;
    logic [9:0] exp;
    sel = s_i;
    @(negedge clk);
    t = 0;
    while (!obs_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (obs_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready: got %b want 1", name, obs_in_ready);
    end
    drv_a = a; drv_b = b; drv_c = c; drv_sub = sb; drv_valid = 1'b1;
    exp_q.push_back(model(width_of(s_i), a, b, c, sb));
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    drv_a = 8'($urandom_range(0, 255)); drv_b = 8'($urandom_range(0, 255));
    drv_c = ~c; drv_sub = ~sb;
    lat = 1;
    while (!obs_out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_chk++;
    if (lat != steps_of(s_i) + 1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, steps_of(s_i) + 1);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
    n_chk++;
    if (obs_res !== exp) begin
      n_fail++;
      $display("FAIL %s result {ovf,c_out,s}: got %h want %h (a=%h b=%h c=%b sub=%b)",
               name, obs_res, exp, a, b, c, sb);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      drv_a = 8'($urandom_range(0, 255)); drv_b = 8'($urandom_range(0, 255));
      n_chk++;
      if (obs_res !== exp || obs_in_ready !== 1'b0 || obs_out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s hold%0d: got res=%h rdy=%b vld=%b want res=%h rdy=0 vld=1",
                 name, i, obs_res, obs_in_ready, obs_out_valid, exp);
      end
    end
    drv_out_ready = 1'b1;
    @(posedge clk);
    #1;
    drv_out_ready = 1'b0;
    n_chk++;
    if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_res !== exp) begin
      n_fail++;
      $display("FAIL %s after handshake: got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=%h",
               name, obs_in_ready, obs_out_valid, obs_res, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drv_valid = 1'b0; drv_out_ready = 1'b0;
    drv_a = 8'h00; drv_b = 8'h00; drv_c = 1'b0; drv_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      n_chk++;
      if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_res !== 10'h000 || obs_dbg !== 2'd0) begin
        n_fail++;
        $display("FAIL reset inst%0d: got rdy=%b vld=%b res=%h st=%0d want rdy=1 vld=0 res=000 st=0",
                 i, obs_in_ready, obs_out_valid, obs_res, obs_dbg);
      end
    end
    rst = 1'b0;
    sel = 0;
  endtask

  task automatic test_directed;
    do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, "c1_ff_plus_01");
    do_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 0, "c1_7f_plus_01");
    do_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 0, "c1_05_minus_07");
    do_op(0, 8'h80, 8'h01, 1'b1, 1'b1, 0, "c1_80_minus_01");
    do_op(2, 8'h80, 8'h80, 1'b1, 1'b0, 0, "c8_80_plus_80_c");
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      do_op((i % 2 == 0) ? 0 : 2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, "rand");
    end
  endtask

  task automatic test_exhaustive_c2;
    for (int v = 0; v < 1024; v++) begin
      do_op(1, 8'(v & 15), 8'((v >> 4) & 15), 1'((v >> 8) & 1), 1'((v >> 9) & 1), 0, "c2_sweep");
    end
  endtask

  task automatic test_backpressure;
    do_op(0, 8'h3C, 8'h5A, 1'b1, 1'b0, 5, "c1_backpressure");
    do_op(2, 8'h10, 8'h20, 1'b0, 1'b1, 3, "c8_backpressure");
  endtask

  task automatic test_reset_mid_run;
    sel = 0;
    @(negedge clk);
    drv_a = 8'hFF; drv_b = 8'h00; drv_c = 1'b0; drv_sub = 1'b0; drv_valid = 1'b1;
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (obs_out_valid !== 1'b0 || obs_res !== 10'h000 || obs_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_run: got vld=%b res=%h rdy=%b want vld=0 res=000 rdy=1",
               obs_out_valid, obs_res, obs_in_ready);
    end
    rst = 1'b0;
    do_op(0, 8'h12, 8'h34, 1'b1, 1'b0, 0, "after_reset_op");
  endtask

  task automatic test_back_to_back;
    int last_acc;
    int n_acc;
    int t;
    logic [9:0] exp;
    last_acc = -1;
    n_acc = 0;
    sel = 0;
    drv_out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (obs_out_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        n_chk++;
        if (obs_res !== exp) begin
          n_fail++;
          $display("FAIL b2b result: got %h want %h", obs_res, exp);
        end
      end
      drv_a = 8'($urandom_range(0, 255)); drv_b = 8'($urandom_range(0, 255));
      drv_c = 1'($urandom_range(0, 1)); drv_sub = 1'($urandom_range(0, 1));
      drv_valid = (cyc < 35);
      if (drv_valid && obs_in_ready) begin
        exp_q.push_back(model(8, drv_a, drv_b, drv_c, drv_sub));
        if (last_acc >= 0) begin
          n_chk++;
          if (cyc - last_acc != 10) begin
            n_fail++;
            $display("FAIL b2b accept spacing: got %0d want 10", cyc - last_acc);
          end
        end
        last_acc = cyc;
        n_acc++;
      end
    end
    t = 0;
    while (exp_q.size() > 0 && t < 20) begin
      @(negedge clk);
      if (obs_out_valid) begin
        exp = exp_q.pop_front();
        n_chk++;
        if (obs_res !== exp) begin
          n_fail++;
          $display("FAIL b2b drain result: got %h want %h", obs_res, exp);
        end
      end
      t++;
    end
    drv_out_ready = 1'b0;
    n_chk++;
    if (n_acc != 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b accepts/pending: got %0d/%0d want 4/0", n_acc, exp_q.size());
    end
  endtask

  initial begin
    sel = 0;
    test_reset();
    test_directed();
    test_random();
    test_exhaustive_c2();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
